// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with GPR/FP load-use stalls and the multi-cycle FPU-add interlock.
// Optional feature macro: FPU_INTERLOCK_EN (FP load-use detection and the fcnt interlock).

package definitions;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
    } x_ctrl_t;

    typedef struct packed {
        logic read_mem;
        logic write_mem;
        logic fpu_to_mem;
        logic branch;
        logic jump;
    } m_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic fpu_write;
    } wb_ctrl_t;

    typedef struct packed {
        logic start;
    } fpu_ctrl_t;

    typedef struct packed {
        x_ctrl_t   x;
        m_ctrl_t   m;
        wb_ctrl_t  wb;
        fpu_ctrl_t fpu;
    } DX_ctrl;

    // All-zero bundle: no register write, memory access, branch or FPU launch.
    localparam DX_ctrl DX_DISABLE = '0;

endpackage

module id_ex_stage
    import definitions::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int FPU_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  DX_ctrl            id_ctrl,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              ex_valid,
    output DX_ctrl            ex_ctrl,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              fpu_busy
);

    // Handshake: the ID instruction transfers into EX on a rising edge where
    // id_valid && id_ready && !flush; a flushed ID instruction is dropped, not held.

    logic              uses_rt;
    logic              ex_is_gpr_load;
    logic              gpr_hazard;
    logic              fp_hazard;
    logic              fpu_hazard;
    logic              stall;
    logic              load_id;
    logic [REG_AW-1:0] id_wreg;

    assign uses_rt        = !id_ctrl.x.alu_src | id_ctrl.m.write_mem;
    assign ex_is_gpr_load = ex_valid & ex_ctrl.m.read_mem & ex_ctrl.wb.reg_write;
    assign id_wreg        = id_ctrl.x.reg_dst ? id_rd : id_rt;

    // $0 is hard-wired zero in the GPR file, so a load into it never creates a dependency.
    assign gpr_hazard = ex_is_gpr_load
                      & (ex_wreg != '0)
                      & ((ex_wreg == id_rs) | (uses_rt & (ex_wreg == id_rt)));

`ifdef FPU_INTERLOCK_EN
    localparam logic [3:0] FPU_LAT_C = 4'(FPU_LAT);

    logic [3:0] fcnt;
    logic       id_is_fp;
    logic       ex_is_lwc1;
    logic       id_reads_fp;

    assign id_is_fp    = id_ctrl.fpu.start | id_ctrl.m.fpu_to_mem | id_ctrl.wb.fpu_write;
    assign ex_is_lwc1  = ex_valid & ex_ctrl.m.read_mem & ex_ctrl.wb.fpu_write;
    assign id_reads_fp = id_ctrl.fpu.start | id_ctrl.m.fpu_to_mem;

    // FP register 0 is a real register, so no zero exclusion here.
    assign fp_hazard  = ex_is_lwc1 & id_reads_fp & ((ex_wreg == id_rs) | (ex_wreg == id_rt));
    assign fpu_busy   = (fcnt != 4'd0);
    assign fpu_hazard = fpu_busy & id_is_fp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt <= 4'd0;
        end else if (flush && ex_valid && ex_ctrl.fpu.start) begin
            // The squashed ADD.S never really launched, so release the FPU at once.
            fcnt <= 4'd0;
        end else if (load_id && id_ctrl.fpu.start) begin
            fcnt <= FPU_LAT_C;
        end else if (fcnt != 4'd0) begin
            fcnt <= fcnt - 4'd1;
        end
    end
`else
    assign fp_hazard  = 1'b0;
    assign fpu_hazard = 1'b0;
    assign fpu_busy   = 1'b0;
`endif

    assign stall    = id_valid & (gpr_hazard | fp_hazard | fpu_hazard) & !flush;
    assign id_ready = !stall;
    assign load_id  = id_valid & !stall & !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= DX_DISABLE;
        end else if (load_id) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= id_ctrl;
        end else begin
            ex_valid <= 1'b0;
            ex_ctrl  <= DX_DISABLE;
        end
    end

    // Operand fields only move on a real load; bubbles leave them stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
        end else if (load_id) begin
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wreg    <= id_wreg;
        end
    end

endmodule
